// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry output buffer toward decode: holds one instruction with its PC and PC+4.
module fetch_buf
  import if_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            consume_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o
);

  logic            valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next_q;

  // Load wins over consume; the controller never asserts both.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      pc_q      <= '0;
      pc_next_q <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      inst_q    <= inst_i;
      pc_q      <= pc_i;
      pc_next_q <= pc_i + XLEN'(PC_STEP);
    end else if (consume_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign inst_o    = inst_q;
  assign pc_o      = pc_q;
  assign pc_next_o = pc_next_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, drives the imem req/gnt/rvalid handshake,
// squashes wrong-path responses after redirects and feeds decode via fetch_buf.
module fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_next,
  output logic [XLEN-1:0] fetch_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target;
  logic            buf_load, buf_consume;

  assign target = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = target;
      end
      REQ: begin
        if (redirect) pc_d = target;
        // A granted old address still owes a response, so it must be drained.
        if (imem_gnt) state_d = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          buf_load = 1'b1;
          pc_d     = pc_q + XLEN'(PC_STEP);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          buf_consume = 1'b1;
          pc_d        = target;
          state_d     = REQ;
        end else if (id_ready) begin
          buf_consume = 1'b1;
          state_d     = REQ;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = target;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_buf #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .clr_i     (reset),
    .load_i    (buf_load),
    .consume_i (buf_consume),
    .inst_i    (imem_rdata),
    .pc_i      (pc_q),
    .valid_o   (id_valid),
    .inst_o    (id_inst),
    .pc_o      (id_pc),
    .pc_next_o (id_pc_next)
  );

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign fetch_pc  = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: per-cycle input/expected-output records.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_inst, id_pc, id_pc_next, fetch_pc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_next  (id_pc_next),
    .fetch_pc    (fetch_pc)
  );

  typedef struct {
    logic        rst, rdr;
    logic [31:0] rpc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst, e_pc, e_pcn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rdr, logic [31:0] rpc, logic gnt, logic rv,
                              logic [31:0] rdata, logic rdy, logic e_req, logic [31:0] e_addr,
                              logic e_vld, logic [31:0] e_inst, logic [31:0] e_pc,
                              logic [31:0] e_pcn);
    vec_t v;
    v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_pcn = e_pcn;
    return v;
  endfunction

  task automatic apply_and_check(input vec_t v, input string name, input int idx);
    reset = v.rst; redirect = v.rdr; redirect_pc = v.rpc; imem_gnt = v.gnt;
    imem_rvalid = v.rv; imem_rdata = v.rdata; id_ready = v.rdy;
    @(posedge clk);
    #1;
    n_checks++;
    if (imem_req === v.e_req && imem_addr === v.e_addr && fetch_pc === v.e_addr &&
        id_valid === v.e_vld && id_inst === v.e_inst && id_pc === v.e_pc &&
        id_pc_next === v.e_pcn) begin
      n_pass++;
    end else begin
      $display("FAIL %s[%0d]: got req=%0b addr=%h fpc=%h vld=%0b inst=%h pc=%h pcn=%h; want req=%0b addr=%h vld=%0b inst=%h pc=%h pcn=%h",
               name, idx, imem_req, imem_addr, fetch_pc, id_valid, id_inst, id_pc, id_pc_next,
               v.e_req, v.e_addr, v.e_vld, v.e_inst, v.e_pc, v.e_pcn);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;

    //              rst rdr rpc           gnt rv rdata         rdy  req addr          vld inst          pc            pcn
    // Reset and sequential fetch, zero-wait memory
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hA0,       1,   0, 32'h4,        1, 32'hA0,       32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h4,        0, 32'hA0,       32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h4,        0, 32'hA0,       32'h0,        32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hA1,       1,   0, 32'h8,        1, 32'hA1,       32'h4,        32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h8,        0, 32'hA1,       32'h4,        32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h8,        0, 32'hA1,       32'h4,        32'h8));
    // Capture at 0x8 with decode stalled for 5 cycles
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hA2,       0,   0, 32'hC,        1, 32'hA2,       32'h8,        32'hC));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 32'h0,      0, 0, 32'h0,        0,   0, 32'hC,        1, 32'hA2,       32'h8,        32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'hC,        0, 32'hA2,       32'h8,        32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'hC,        0, 32'hA2,       32'h8,        32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hA3,       1,   0, 32'h10,       1, 32'hA3,       32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h10,       0, 32'hA3,       32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h10,       0, 32'hA3,       32'hC,        32'h10));
    // Redirect in WAIT without rvalid -> DRAIN; stale 0x10 response dropped
    vecs.push_back(mk(0, 1, 32'h100,      0, 0, 32'h0,        1,   0, 32'h100,      0, 32'hA3,       32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h100,      0, 32'hA3,       32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hDEAD,     1,   1, 32'h100,      0, 32'hA3,       32'hC,        32'h10));
    // Redirect in REQ with gnt=0: next address presented immediately
    vecs.push_back(mk(0, 1, 32'h200,      0, 0, 32'h0,        1,   1, 32'h200,      0, 32'hA3,       32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h200,      0, 32'hA3,       32'hC,        32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hB0,       1,   0, 32'h204,      1, 32'hB0,       32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h204,      0, 32'hB0,       32'h200,      32'h204));
    // Redirect in REQ with gnt=1: drain the accepted 0x204 request first
    vecs.push_back(mk(0, 1, 32'h200,      1, 0, 32'h0,        1,   0, 32'h200,      0, 32'hB0,       32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hBAD,      1,   1, 32'h200,      0, 32'hB0,       32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h200,      0, 32'hB0,       32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hB1,       0,   0, 32'h204,      1, 32'hB1,       32'h200,      32'h204));
    // Redirect in HOLD to a misaligned target, with id_ready also high
    vecs.push_back(mk(0, 1, 32'h303,      0, 0, 32'h0,        1,   1, 32'h300,      0, 32'hB1,       32'h200,      32'h204));
    // PC wrap at the top of the address space
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,0, 0, 32'h0,        1,   1, 32'hFFFF_FFFC,0, 32'hB1,       32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'hFFFF_FFFC,0, 32'hB1,       32'h200,      32'h204));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0,       0,   0, 32'h0,        1, 32'hC0,       32'hFFFF_FFFC,32'h0));
    vecs.push_back(mk(0, 1, 32'h40,       0, 0, 32'h0,        1,   1, 32'h40,       0, 32'hC0,       32'hFFFF_FFFC,32'h0));
    // Reset in WAIT, stale rvalid on the following cycle is ignored
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h40,       0, 32'hC0,       32'hFFFF_FFFC,32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hEE,       1,   1, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h13,       32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hD0,       0,   0, 32'h4,        1, 32'hD0,       32'h0,        32'h4));

    for (int i = 0; i < vecs.size(); i++) apply_and_check(vecs[i], "vec", i);

    // Redirect taken while in IDLE right after reset
    apply_and_check(mk(1, 0, 32'h0,   0, 0, 32'h0, 0,  0, 32'h0,   0, 32'h13, 32'h0, 32'h0), "idle_rdr", 0);
    apply_and_check(mk(0, 1, 32'h505, 0, 0, 32'h0, 0,  1, 32'h504, 0, 32'h13, 32'h0, 32'h0), "idle_rdr", 1);

    // Grant delayed by memory: address must hold, then a bounded wait for the response path
    begin
      int budget;
      for (int i = 0; i < 3; i++)
        apply_and_check(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h504, 0, 32'h13, 32'h0, 32'h0), "gnt_stall", i);
      apply_and_check(mk(0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h504, 0, 32'h13, 32'h0, 32'h0), "gnt_late", 0);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE1; id_ready = 1'b0;
      budget = 0;
      do begin
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        budget++;
      end while (!id_valid && budget < 10);
      n_checks++;
      if (id_valid === 1'b1 && id_inst === 32'hE1 && id_pc === 32'h504 &&
          id_pc_next === 32'h508 && budget == 1)
        n_pass++;
      else
        $display("FAIL late_resp: got vld=%0b inst=%h pc=%h pcn=%h after %0d cycles; want vld=1 inst=e1 pc=504 pcn=508 after 1",
                 id_valid, id_inst, id_pc, id_pc_next, budget);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage against an instruction memory with a request/grant/response handshake.
- Owns the fetch PC register and presents one instruction at a time to decode through a single-entry valid/ready output buffer.
- Applies branch/jump redirects from execute and discards any in-flight wrong-path response.
- Sits between the PC/IF datapath and the ID stage; it replaces a free-running PC with a stall- and redirect-aware sequencer.

Parameters:
- XLEN, 32, width of PC and address buses.
- RESET_PC, 32'h0000_0000, fetch PC value after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect  input  1  branch/jump taken from EX; single-cycle pulse.
- redirect_pc  input  XLEN  target PC, valid when redirect=1; bits [1:0] ignored and forced to 0.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address, equal to fetch_pc.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  response data valid; at most one per granted request, and at least one cycle after the grant.
- imem_rdata  input  32  instruction word.
- id_valid  output  1  output buffer holds an instruction.
- id_ready  input  1  decode accepts the instruction this cycle.
- id_inst  output  32  buffered instruction.
- id_pc  output  XLEN  PC of id_inst.
- id_pc_next  output  XLEN  id_pc + 4.
- fetch_pc  output  XLEN  current fetch PC register.

Behaviour:
- Reset, when reset=1 at a clock edge:
  - state=IDLE, fetch_pc=RESET_PC.
  - id_valid=0, id_inst=NOP_INST (32'h0000_0013), id_pc=0, id_pc_next=0.
  - reset has priority over every other input, including in any mid-transaction state; an outstanding memory response arriving after reset is ignored.
- Output decode:
  - imem_req=1 only in state REQ.
  - imem_addr=fetch_pc at all times.
  - All outputs are registered except imem_req, which is decoded from state only.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN. The redirect action in every state loads fetch_pc<=redirect_pc with bits [1:0]=00.
- IDLE:
  - next state REQ.
  - redirect: apply redirect action, then go to REQ.
- REQ:
  - gnt=1, redirect=0: go to WAIT.
  - gnt=1, redirect=1: apply redirect action, then go to DRAIN, because the old address was already accepted.
  - gnt=0, redirect=1: apply redirect action, stay in REQ; the new address is presented next cycle.
  - gnt=0, redirect=0: stay in REQ, hold the address.
- WAIT:
  - rvalid=1, redirect=0: capture the response:
    - id_inst<=rdata, id_pc<=fetch_pc, id_pc_next<=fetch_pc+4, id_valid<=1.
    - fetch_pc<=fetch_pc+4.
    - go to HOLD.
  - rvalid=1, redirect=1: discard the data, apply redirect action, go to REQ.
  - rvalid=0, redirect=1: apply redirect action, go to DRAIN.
- HOLD:
  - id_ready=1, redirect=0: id_valid<=0, go to REQ.
  - redirect=1 (overrides id_ready): id_valid<=0, apply redirect action, go to REQ. Decode must not consume in this cycle; id_valid drops next cycle.
- DRAIN:
  - wait for rvalid and discard the data; then go to REQ.
  - redirect in DRAIN: apply redirect action, stay in DRAIN (or go to REQ if rvalid arrives the same cycle).
- Arithmetic:
  - All PC adds are modulo 2^XLEN, so 32'hFFFF_FFFC+4 wraps to 0.
  - imem_rdata is never modified.
- Invariants:
  - At most one outstanding memory request.
  - id_valid=1 only in HOLD.
  - Buffer contents are stable while id_valid=1 and id_ready=0.
- Throughput with zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): one instruction per 3 cycles.
  - REQ, then WAIT (capture), then HOLD (consume).
- Latency from the redirect edge to the first imem_req at the target:
  - 1 cycle from IDLE, WAIT or HOLD.
  - 0 extra cycles when in REQ.
  - DRAIN adds cycles until the wrong-path response returns.

Decomposition:
- Package if_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, DRAIN}.
  - NOP_INST = 32'h0000_0013.
  - PC_STEP = 4.
- One sub-module, fetch_buf: single-entry output register (inst, pc, pc_next, valid) with load, consume and clear controls.
- FSM and fetch_pc live in fetch_ctrl.

Test Plan:
1. Reset and sequential fetch:
   - Stimulus: reset 2 cycles, zero-wait memory, id_ready=1.
   - Response: imem_addr 0,4,8,C on successive REQ cycles; id_pc matches; id_pc_next=id_pc+4; one id_valid pulse every 3 cycles.
2. Decode stall:
   - Stimulus: hold id_ready=0 for 5 cycles after the capture at PC 0x8.
   - Response: id_valid stays 1; id_inst and id_pc=0x8 stable; imem_req=0; fetch resumes at 0xC the cycle after id_ready=1.
3. Redirect in WAIT without rvalid:
   - Stimulus: redirect to 0x100 while waiting on 0x10; rvalid for 0x10 arrives 2 cycles later.
   - Response: state DRAIN; data dropped; id_valid never 1 for 0x10; next imem_addr=0x100.
4. Redirect in REQ:
   - With gnt=0: next cycle imem_addr=0x200 and no drain.
   - With gnt=1 at the same edge: DRAIN, old response discarded, then REQ at 0x200.
5. Redirect in HOLD, and alignment:
   - Stimulus: redirect to 0x303 with id_ready=1 in the same cycle.
   - Response: id_valid=0 next cycle; fetch_pc=0x300.
6. PC wrap and reset mid-transaction:
   - Stimulus: fetch at 0xFFFF_FFFC.
   - Response: id_pc_next=0 and fetch_pc=0.
   - Stimulus: assert reset in WAIT and deliver rvalid in the cycle after.
   - Response: id_valid stays 0; fetch restarts at RESET_PC.
